// File: rtl/systolic_writeback_pkg.sv
// Shared types for the result writeback stage.
package systolic_writeback_pkg;

    // Tile drain sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        DONE
    } wb_state_t;

    // Saturation ceiling for the lifetime write counter.
    localparam logic [31:0] WB_COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/systolic_writeback_skew_delay_line.sv
// Fixed-length register chain used to realign skewed systolic outputs.
// A depth of zero degenerates to a plain wire.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = &{1'b0, clk, rst_n};
            assign dout = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift the input one stage per clock; reset clears every stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_writeback.sv
// Drains one NxN result tile from the PE array: deskews the columns,
// applies optional ReLU, buffers rows and writes them out word by word.
module systolic_writeback
    import systolic_writeback_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    addr_C,
    input  logic [8:0]           n,
    input  logic                 relu_en,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   result_col,
    input  logic                 mem_grant,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          writes_count,
    output logic                 err_extra
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    wb_state_t state, state_next;

    logic [ADDR_W-1:0] base_q;
    logic [8:0]        stride_q;
    logic              relu_q;

    logic [CNT_W-1:0]  in_rows;
    logic [CNT_W-1:0]  push_rows;
    logic [CNT_W-1:0]  wr_row;
    logic [PTR_W-1:0]  wr_col;

    logic tile_active;
    logic accept_valid;
    logic extra_valid;
    logic aligned_valid;
    logic push;
    logic pop;
    logic pending;
    logic arm;

    logic [N-1:0][WIDTH-1:0] aligned_row;
    logic [N-1:0][WIDTH-1:0] relu_row;
    logic [N-1:0][WIDTH-1:0] fifo_mem [N];
    logic [PTR_W-1:0]        wptr;
    logic [PTR_W-1:0]        rptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [ADDR_W-1:0]       row_off;
    logic [ADDR_W-1:0]       addr_sum;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign arm          = start && (state == IDLE);
    assign tile_active  = (state == ACTIVE) || (state == FLUSH);
    assign accept_valid = in_valid && tile_active && (in_rows < CNT_W'(N));
    assign extra_valid  = in_valid && tile_active && !(in_rows < CNT_W'(N));
    assign push         = aligned_valid;
    assign pending      = (fifo_count != '0);
    assign mem_write    = pending && mem_grant;
    assign pop          = mem_write && (wr_col == PTR_W'(N - 1));

    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_col
            skew_delay_line #(
                .DEPTH (N - 1 - j),
                .WIDTH (WIDTH)
            ) u_col_delay (
                .clk   (clk),
                .rst_n (rst),
                .din   (result_col[j*WIDTH +: WIDTH]),
                .dout  (aligned_row[j])
            );
        end
    endgenerate

    skew_delay_line #(
        .DEPTH (N - 1),
        .WIDTH (1)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst),
        .din   (accept_valid),
        .dout  (aligned_valid)
    );

    // Clamp negative elements of the aligned row to zero when ReLU is armed.
    always_comb begin
        relu_row = aligned_row;
        for (int k = 0; k < N; k++) begin
            if (relu_q && aligned_row[k][WIDTH-1]) begin
                relu_row[k] = '0;
            end
        end
    end

    // Write address is base + row*stride + column, wrapping in the address width.
    always_comb begin
        row_off  = ADDR_W'(32'(wr_row) * 32'(stride_q));
        addr_sum = base_q + row_off + ADDR_W'(wr_col);
        mem_addr = '0;
        mem_data = '0;
        if (mem_write) begin
            mem_addr = addr_sum;
            mem_data = fifo_mem[rptr][wr_col];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the status outputs derived from the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (push_rows == CNT_W'(N)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (!pending) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the tile context on start and track input, push and write positions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            stride_q  <= '0;
            relu_q    <= 1'b0;
            in_rows   <= '0;
            push_rows <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
        end else if (arm) begin
            base_q    <= addr_C;
            stride_q  <= n;
            relu_q    <= relu_en;
            in_rows   <= '0;
            push_rows <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
        end else begin
            if (accept_valid) begin
                in_rows <= in_rows + CNT_W'(1);
            end
            if (push) begin
                push_rows <= push_rows + CNT_W'(1);
            end
            if (mem_write) begin
                if (wr_col == PTR_W'(N - 1)) begin
                    wr_col <= '0;
                    wr_row <= wr_row + CNT_W'(1);
                end else begin
                    wr_col <= wr_col + PTR_W'(1);
                end
            end
        end
    end

    // Row FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Row storage; occupancy alone decides validity, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= relu_row;
        end
    end

    // Lifetime write counter (saturating) and sticky extra-row flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writes_count <= '0;
            err_extra    <= 1'b0;
        end else begin
            if (mem_write && (writes_count != WB_COUNT_MAX)) begin
                writes_count <= writes_count + 32'd1;
            end
            if (extra_valid) begin
                err_extra <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed self-checking bench for the systolic result writeback stage.
module tb_systolic_writeback;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   addr_C;
    logic [8:0]      n;
    logic            relu_en;
    logic            in_valid;
    logic [N*W-1:0]  result_col;
    logic            mem_grant;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_data;
    logic            busy;
    logic            done;
    logic [31:0]     writes_count;
    logic            err_extra;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;
    bit grant_toggle  = 1'b0;

    logic [AW-1:0] wr_addr_q [$];
    logic [W-1:0]  wr_data_q [$];
    int first_write_cyc;
    int first_valid_cyc;
    int done_cyc;
    int done_count;
    int nogrant_writes;
    int saved_size;

    logic signed [W-1:0] mat [5][N];

    systolic_writeback #(.N(N), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .addr_C       (addr_C),
        .n            (n),
        .relu_en      (relu_en),
        .in_valid     (in_valid),
        .result_col   (result_col),
        .mem_grant    (mem_grant),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .busy         (busy),
        .done         (done),
        .writes_count (writes_count),
        .err_extra    (err_extra)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Grant is either held high or toggled every cycle.
    always @(posedge clk) begin
        #1;
        mem_grant = grant_toggle ? ~mem_grant : 1'b1;
    end

    // Log every write and every done pulse mid-cycle.
    always @(negedge clk) begin
        if (mem_write) begin
            if (wr_addr_q.size() == 0) first_write_cyc = cyc;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            if (!mem_grant) nogrant_writes++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic fill_matrix();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < N; c++) begin
                mat[r][c] = (r < N) ? W'(10 * r + c) : W'(99);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic start_tile(input logic [AW-1:0] base, input logic [8:0] stride, input logic relu);
        @(posedge clk); #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_count      = 0;
        nogrant_writes  = 0;
        first_write_cyc = -1;
        done_cyc        = -1;
        addr_C  = base;
        n       = stride;
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic apply_stimulus(input int nrows);
        for (int k = 0; k < nrows + N - 1; k++) begin
            in_valid = (k < nrows);
            for (int j = 0; j < N; j++) begin
                int r;
                r = k - j;
                result_col[j*W +: W] = (r >= 0 && r < nrows) ? mat[r][j] : W'(0);
            end
            if (k == 0) first_valid_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        result_col = '0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_count == 0; i++) @(posedge clk);
        #1;
        check_output("done_seen", {63'd0, done_count != 0}, 64'd1);
    endtask

    task automatic check_tile(input int base, input int stride, input bit relu);
        repeat (5) @(posedge clk);
        #1;
        check_output("write_count", 64'(wr_addr_q.size()), 64'd16);
        check_output("single_done", 64'(done_count), 64'd1);
        check_output("writes_without_grant", 64'(nogrant_writes), 64'd0);
        check_output("busy_after_done", {63'd0, busy}, 64'd0);
        for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
            int r;
            int c;
            logic [AW-1:0] ea;
            logic [W-1:0]  ed;
            r  = i / N;
            c  = i % N;
            ea = AW'(base + r * stride + c);
            ed = (relu && mat[r][c] < 0) ? W'(0) : mat[r][c];
            check_output($sformatf("addr[%0d]", i), 64'(wr_addr_q[i]), 64'(ea));
            check_output($sformatf("data[%0d]", i), 64'(wr_data_q[i]), 64'(ed));
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        addr_C     = '0;
        n          = '0;
        relu_en    = 1'b0;
        in_valid   = 1'b0;
        result_col = '0;
        mem_grant  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_output("rst_mem_data", 64'(mem_data), 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_done", {63'd0, done}, 64'd0);
        check_output("rst_writes_count", 64'(writes_count), 64'd0);
        check_output("rst_err_extra", {63'd0, err_extra}, 64'd0);
        rst = 1'b1;

        $display("[TB] tile 1: continuous grant");
        fill_matrix();
        start_tile(12'h100, 9'd4, 1'b0);
        apply_stimulus(4);
        wait_done(100);
        check_tile(32'h100, 4, 1'b0);
        check_output("first_write_latency", 64'(first_write_cyc - first_valid_cyc), 64'd4);
        check_output("done_latency", 64'(done_cyc - first_valid_cyc), 64'd21);
        check_output("data_row1_col0", 64'(wr_data_q[4]), 64'd10);
        check_output("addr_last", 64'(wr_addr_q[15]), 64'h10F);
        check_output("writes_count_t1", 64'(writes_count), 64'd16);
        check_output("err_extra_t1", {63'd0, err_extra}, 64'd0);

        $display("[TB] tile 2: toggling grant");
        do_reset();
        grant_toggle = 1'b1;
        start_tile(12'h100, 9'd4, 1'b0);
        apply_stimulus(4);
        wait_done(200);
        check_tile(32'h100, 4, 1'b0);
        check_output("toggle_done_later", {63'd0, (done_cyc - first_valid_cyc) > 21}, 64'd1);
        check_output("writes_count_t2", 64'(writes_count), 64'd16);
        grant_toggle = 1'b0;

        $display("[TB] tile 3: relu");
        do_reset();
        fill_matrix();
        mat[1][2] = -16'sd5;
        mat[3][0] = -16'sd32768;
        start_tile(12'h100, 9'd4, 1'b1);
        apply_stimulus(4);
        wait_done(100);
        check_tile(32'h100, 4, 1'b1);
        check_output("relu_m5", 64'(wr_data_q[6]), 64'd0);
        check_output("relu_min", 64'(wr_data_q[12]), 64'd0);
        check_output("relu_keep", 64'(wr_data_q[7]), 64'd13);

        $display("[TB] tile 4: address wrap");
        do_reset();
        fill_matrix();
        start_tile(12'hFFE, 9'd8, 1'b0);
        apply_stimulus(4);
        wait_done(100);
        check_tile(32'hFFE, 8, 1'b0);
        check_output("wrap_a0", 64'(wr_addr_q[0]), 64'hFFE);
        check_output("wrap_a1", 64'(wr_addr_q[1]), 64'hFFF);
        check_output("wrap_a2", 64'(wr_addr_q[2]), 64'h000);
        check_output("wrap_a3", 64'(wr_addr_q[3]), 64'h001);
        check_output("wrap_row1", 64'(wr_addr_q[4]), 64'h006);

        $display("[TB] tile 5: extra row then normal tile");
        do_reset();
        fill_matrix();
        start_tile(12'h100, 9'd4, 1'b0);
        apply_stimulus(5);
        wait_done(100);
        check_tile(32'h100, 4, 1'b0);
        check_output("err_extra_set", {63'd0, err_extra}, 64'd1);
        start_tile(12'h200, 9'd4, 1'b0);
        apply_stimulus(4);
        wait_done(100);
        check_tile(32'h200, 4, 1'b0);
        check_output("err_extra_sticky", {63'd0, err_extra}, 64'd1);
        check_output("writes_count_t5", 64'(writes_count), 64'd32);

        $display("[TB] tile 6: reset mid-drain");
        do_reset();
        start_tile(12'h100, 9'd4, 1'b0);
        apply_stimulus(4);
        for (int i = 0; i < 100 && wr_addr_q.size() < 9; i++) @(negedge clk);
        check_output("reached_row2", {63'd0, wr_addr_q.size() >= 9}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_mem_write", {63'd0, mem_write}, 64'd0);
        check_output("abort_mem_addr", 64'(mem_addr), 64'd0);
        check_output("abort_mem_data", 64'(mem_data), 64'd0);
        check_output("abort_busy", {63'd0, busy}, 64'd0);
        check_output("abort_writes_count", 64'(writes_count), 64'd0);
        saved_size = wr_addr_q.size();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_output("abort_no_more_writes", 64'(wr_addr_q.size()), 64'(saved_size));
        check_output("abort_no_done", 64'(done_count), 64'd0);
        start_tile(12'h100, 9'd4, 1'b0);
        apply_stimulus(4);
        wait_done(100);
        check_tile(32'h100, 4, 1'b0);
        check_output("writes_count_t6", 64'(writes_count), 64'd16);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
